uart_rx: RTL

//   8N1 UART receiver, the counterpart of uart_tx on the same serial link. Samples rx with
//   16x oversampling, using the same baud_div prescaler convention as uart_tx.

---
 rtl/uart_rx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling, 3-sample majority voting
// and a one-deep holding register with an avail/rd handshake.
module uart_rx #(
  parameter int unsigned OVS     = 16,
  parameter int unsigned SYNC_FF = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        en,
  input  logic [15:0] baud_div,
  input  logic        rx,
  input  logic        rd,
  output logic [7:0]  data,
  output logic        done,
  output logic        avail,
  output logic        frame_err,
  output logic        overrun
);

  localparam int unsigned TW = $clog2(OVS);
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [SYNC_FF-1:0] sync_q;
  logic               rxs;
  logic               rxs_q;
  logic [15:0]        presc;
  logic [15:0]        div_q;
  logic [TW-1:0]      tick_cnt;
  logic [TW-1:0]      tick_nxt;
  logic [2:0]         bit_cnt;
  logic [1:0]         smp;
  logic [DW-1:0]      shreg;
  logic               tick;
  logic               start_edge;
  logic               maj;
  logic               s9;
  logic               bit_end;

  // tick_cnt counts ticks elapsed in the current bit; the start edge is tick 0,
  // so "tick k" is the prescaler tick that advances the count to k.
  assign rxs        = sync_q[SYNC_FF-1];
  assign tick       = (presc == div_q);
  assign tick_nxt   = tick_cnt + TW'(1);
  assign start_edge = rxs_q & ~rxs;
  assign maj        = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
  assign s9         = tick && (tick_nxt == TW'(9));
  assign bit_end    = tick && (tick_cnt == TW'(OVS - 1));

  // rx synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sync_q <= '1;
      rxs_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_FF-2:0], rx};
      rxs_q  <= rxs;
    end
  end

  // Prescaler; baud_div is picked up only at a reload, start edge re-phases it
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      presc <= '0;
      div_q <= '0;
    end else if (!en || tick || (state == IDLE && start_edge)) begin
      presc <= '0;
      div_q <= baud_div;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  // Frame FSM: start validation, data shifting, stop check and byte delivery
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      smp       <= '0;
      shreg     <= '0;
      data      <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (tick && state != IDLE) begin
        tick_cnt <= tick_nxt;
        if (tick_nxt == TW'(7)) smp[0] <= rxs;
        if (tick_nxt == TW'(8)) smp[1] <= rxs;
      end
      if (!en) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start_edge) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (s9 && maj) begin
              state <= IDLE;
            end else if (bit_end) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            if (s9) shreg <= {maj, shreg[DW-1:1]};
            if (bit_end) begin
              if (bit_cnt == 3'd7) state <= STOP;
              else                 bit_cnt <= bit_cnt + 3'd1;
            end
          end
          STOP: begin
            // Leave mid stop bit so a back-to-back start edge is not missed
            if (s9) begin
              data      <= shreg;
              frame_err <= ~maj;
              done      <= 1'b1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Holding-register handshake; rd during the done cycle suppresses overrun
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      avail   <= 1'b0;
      overrun <= 1'b0;
    end else if (done) begin
      avail <= 1'b1;
      if (avail && !rd) overrun <= 1'b1;
    end else if (rd) begin
      avail   <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule
